sram_byte_en_arbiter: RTL and testbench

SRAM_BYTE_EN_ARBITER -- requirements
Module: sram_byte_en_arbiter

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/sram_arb_rr2.sv | 67 ++++++
 rtl/sram_byte_en_arbiter.sv | 103 ++++++++++
 tb/tb_sram_byte_en_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: ownership FSM states and port index.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef logic port_idx_t;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-requester round-robin selector with locked tenures capped at MAX_LOCK accesses.
// Grant is combinational from the current requests; ownership and pointer are registered.
module sram_arb_rr2
    import sram_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    output logic [1:0] o_gnt,
    output port_idx_t  o_win
);

    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_e       r_state;
    port_idx_t        r_rr_last;
    logic [CNT_W-1:0] r_lock_cnt;

    logic [1:0] w_gnt;
    port_idx_t  w_win;
    logic       w_any;
    logic       w_hold;

    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            case (r_state)
                ST_OWN0: w_gnt = {1'b0, i_req[0]};
                ST_OWN1: w_gnt = {i_req[1], 1'b0};
                default: begin
                    // On a tie the port that did not win last time goes first.
                    if (&i_req) w_gnt = r_rr_last ? 2'b01 : 2'b10;
                    else        w_gnt = i_req;
                end
            endcase
        end
    end

    assign w_win  = w_gnt[1];
    assign w_any  = |w_gnt;
    assign w_hold = i_lock[w_win] && (r_lock_cnt != LOCK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_last  <= 1'b1;
            r_lock_cnt <= '0;
        end else if (w_any) begin
            r_rr_last <= w_win;
            if (w_hold) begin
                r_state    <= w_win ? ST_OWN1 : ST_OWN0;
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end else begin
                r_state    <= ST_IDLE;
                r_lock_cnt <= '0;
            end
        end
    end

    assign o_gnt = w_gnt;
    assign o_win = w_win;

endmodule

// File: rtl/sram_byte_en_arbiter.sv
// Two-master arbiter in front of a single-port byte-enabled SRAM with 1-cycle read latency.
// Selection lives in sram_arb_rr2; this level muxes the winner onto the SRAM and tracks rvalid.
module sram_byte_en_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 16,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic                  m0_we,
    input  logic [ADDR_BITS-1:0]  m0_addr,
    input  logic [BE_WIDTH-1:0]   m0_byte_en,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_read_data,

    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic                  m1_we,
    input  logic [ADDR_BITS-1:0]  m1_addr,
    input  logic [BE_WIDTH-1:0]   m1_byte_en,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_read_data,

    output logic [ADDR_BITS-1:0]  sram_addr,
    output logic                  sram_read_en,
    output logic                  sram_write_en,
    output logic [BE_WIDTH-1:0]   sram_byte_en,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);

    logic [1:0] w_req;
    logic [1:0] w_lock;
    logic [1:0] w_we;
    logic [1:0] w_gnt;
    logic [1:0] w_rd_gnt;
    port_idx_t  w_win;
    logic       w_any;

    logic                  w_sel_we;
    logic [ADDR_BITS-1:0]  w_sel_addr;
    logic [BE_WIDTH-1:0]   w_sel_be;
    logic [DATA_WIDTH-1:0] w_sel_wd;

    logic [1:0] r_rvalid;

    assign w_req  = {m1_req,  m0_req};
    assign w_lock = {m1_lock, m0_lock};
    assign w_we   = {m1_we,   m0_we};

    sram_arb_rr2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_rr2 (
        .clk    (clk),
        .rst    (rst),
        .i_req  (w_req),
        .i_lock (w_lock),
        .o_gnt  (w_gnt),
        .o_win  (w_win)
    );

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];
    assign w_any  = |w_gnt;

    assign w_sel_we   = w_win ? m1_we         : m0_we;
    assign w_sel_addr = w_win ? m1_addr       : m0_addr;
    assign w_sel_be   = w_win ? m1_byte_en    : m0_byte_en;
    assign w_sel_wd   = w_win ? m1_write_data : m0_write_data;

    // Idle bus is all zeros so the SRAM never sees a stale address or strobe.
    assign sram_write_en   = w_any & w_sel_we;
    assign sram_read_en    = w_any & ~w_sel_we;
    assign sram_addr       = w_any ? w_sel_addr : '0;
    assign sram_byte_en    = sram_write_en ? w_sel_be : '0;
    assign sram_write_data = w_any ? w_sel_wd : '0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign w_rd_gnt[gi] = w_gnt[gi] & ~w_we[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) r_rvalid <= '0;
        else     r_rvalid <= w_rd_gnt;
    end

    // Gating with rst drops a read whose data phase collides with reset.
    assign m0_rvalid    = r_rvalid[0] & ~rst;
    assign m1_rvalid    = r_rvalid[1] & ~rst;
    assign m0_read_data = sram_read_data;
    assign m1_read_data = sram_read_data;

endmodule

// File: tb/tb_sram_byte_en_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sram_byte_en_arbiter;

    localparam int AB = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int ML = 16;
    localparam int NADDR = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
    logic [AB-1:0] m0_addr;
    logic [BW-1:0] m0_byte_en;
    logic [DW-1:0] m0_write_data, m0_read_data;
    logic          m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
    logic [AB-1:0] m1_addr;
    logic [BW-1:0] m1_byte_en;
    logic [DW-1:0] m1_write_data, m1_read_data;
    logic [AB-1:0] sram_addr;
    logic          sram_read_en, sram_write_en;
    logic [BW-1:0] sram_byte_en;
    logic [DW-1:0] sram_write_data, sram_read_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_byte_en_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_byte_en(m0_byte_en), .m0_write_data(m0_write_data),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_read_data(m0_read_data),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_byte_en(m1_byte_en), .m1_write_data(m1_write_data),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_read_data(m1_read_data),
        .sram_addr(sram_addr), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
        .sram_byte_en(sram_byte_en), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data)
    );

    // Behavioural SRAM: byte-masked writes, registered read.
    logic [DW-1:0] sram_mem [0:NADDR-1];
    always @(posedge clk) begin
        if (sram_write_en)
            for (int b = 0; b < BW; b++)
                if (sram_byte_en[b]) sram_mem[sram_addr[4:0]][b*8 +: 8] <= sram_write_data[b*8 +: 8];
        if (sram_read_en) sram_read_data <= sram_mem[sram_addr[4:0]];
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [0:NADDR-1];
    int owner     = -1;   // port holding a locked tenure, -1 none
    int run_len   = 0;    // accesses already made in the current tenure
    int last_win  = 1;
    int pend_port = -1;
    logic [DW-1:0] pend_data;

    int            exp_win;
    logic [1:0]    exp_gnt, exp_rvalid;
    logic [DW-1:0] exp_rdata, exp_wd;
    logic          exp_ren, exp_wen;
    logic [AB-1:0] exp_addr;
    logic [BW-1:0] exp_be;

    task automatic model_eval();
        exp_win = -1;
        if (!rst) begin
            if (owner == 0)                exp_win = m0_req ? 0 : -1;
            else if (owner == 1)           exp_win = m1_req ? 1 : -1;
            else if (m0_req && m1_req)     exp_win = 1 - last_win;
            else if (m0_req)               exp_win = 0;
            else if (m1_req)               exp_win = 1;
        end
        exp_gnt = 2'b00; exp_ren = 1'b0; exp_wen = 1'b0;
        exp_addr = '0; exp_be = '0; exp_wd = '0;
        if (exp_win == 0) begin
            exp_gnt = 2'b01; exp_wen = m0_we; exp_ren = !m0_we; exp_addr = m0_addr;
            exp_be = m0_we ? m0_byte_en : 4'h0; exp_wd = m0_write_data;
        end else if (exp_win == 1) begin
            exp_gnt = 2'b10; exp_wen = m1_we; exp_ren = !m1_we; exp_addr = m1_addr;
            exp_be = m1_we ? m1_byte_en : 4'h0; exp_wd = m1_write_data;
        end
        exp_rvalid = 2'b00;
        if (!rst && pend_port == 0) exp_rvalid = 2'b01;
        if (!rst && pend_port == 1) exp_rvalid = 2'b10;
        exp_rdata = pend_data;
    endtask

    task automatic model_commit();
        logic lk;
        if (rst) begin
            owner = -1; run_len = 0; last_win = 1; pend_port = -1;
            return;
        end
        pend_port = -1;
        if (exp_win >= 0) begin
            lk = (exp_win == 0) ? m0_lock : m1_lock;
            last_win = exp_win;
            if (lk && (run_len + 1 < ML)) begin owner = exp_win; run_len++; end
            else                          begin owner = -1; run_len = 0; end
            if (exp_wen) begin
                for (int b = 0; b < BW; b++)
                    if (exp_be[b]) ref_mem[exp_addr[4:0]][b*8 +: 8] = exp_wd[b*8 +: 8];
            end else begin
                pend_port = exp_win;
                pend_data = ref_mem[exp_addr[4:0]];
            end
            $display("txn t=%0t m%0d %s addr=%0h be=%b wd=%h lock=%b", $time, exp_win,
                     exp_wen ? "WR" : "RD", exp_addr, exp_be, exp_wd, lk);
        end
    endtask

    task automatic look();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input int p, input logic req, input logic lock, input logic we,
                         input logic [AB-1:0] addr, input logic [BW-1:0] be, input logic [DW-1:0] wd);
        if (p == 0) begin
            m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_byte_en = be; m0_write_data = wd;
        end else begin
            m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_byte_en = be; m1_write_data = wd;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic apply_reset();
        idle_all();
        rst = 1'b1;
        look(); tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 10'h1, 4'hF, 32'h1);
        drive(1, 1'b1, 1'b1, 1'b1, 10'h2, 4'hF, 32'h2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            n_vec++;
            if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, sram_read_en, sram_write_en} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc %0d got gnt=%b%b rv=%b%b ren=%b wen=%b want all 0",
                         i, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, sram_read_en, sram_write_en);
            end
            tick();
        end
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_init_mem();
        for (int a = 0; a < NADDR; a++) begin
            drive(0, 1'b1, 1'b0, 1'b1, AB'(a), 4'hF, $urandom);
            look();
            n_vec++;
            if (!(m0_gnt === 1'b1 && sram_write_en === 1'b1 && sram_addr === AB'(a) &&
                  sram_write_data === m0_write_data && sram_byte_en === 4'hF)) begin
                n_bad++;
                $display("FAIL init_write addr %0d got gnt=%b wen=%b addr=%0h be=%b want 1 1 %0h 1111",
                         a, m0_gnt, sram_write_en, sram_addr, sram_byte_en, a);
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_single_read();
        logic [DW-1:0] want;
        want = 32'hDEADBEEF;
        drive(1, 1'b1, 1'b0, 1'b1, 10'h005, 4'hF, want);
        look(); tick();
        idle_all();
        drive(0, 1'b1, 1'b0, 1'b0, 10'h005, 4'hF, 32'h0);
        look();
        n_vec++;
        if (!(m0_gnt === 1'b1 && m1_gnt === 1'b0 && sram_read_en === 1'b1 && sram_write_en === 1'b0 &&
              sram_addr === 10'h005 && sram_byte_en === 4'h0)) begin
            n_bad++;
            $display("FAIL single_read_issue got gnt=%b%b ren=%b wen=%b addr=%0h be=%b want 01 1 0 5 0000",
                     m1_gnt, m0_gnt, sram_read_en, sram_write_en, sram_addr, sram_byte_en);
        end
        tick();
        idle_all();
        look();
        n_vec++;
        if (!(m0_rvalid === 1'b1 && m1_rvalid === 1'b0 && m0_read_data === want)) begin
            n_bad++;
            $display("FAIL single_read_data got rv=%b%b data=%h want rv=01 data=%h",
                     m1_rvalid, m0_rvalid, m0_read_data, want);
        end
        tick();
        look();
        n_vec++;
        if (m0_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_read_pulse got m0_rvalid=%b want 0", m0_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] want;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, AB'($urandom_range(0, NADDR-1)), 4'hF, 32'h0);
            drive(1, 1'b1, 1'b0, 1'b0, AB'($urandom_range(0, NADDR-1)), 4'hF, 32'h0);
            look();
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_vec++;
            if ({m1_gnt, m0_gnt} !== want) begin
                n_bad++;
                $display("FAIL contention cyc %0d got gnt=%b%b want %b", i, m1_gnt, m0_gnt, want);
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_lock();
        apply_reset();
        drive(1, 1'b1, 1'b0, 1'b0, 10'h7, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, 1'b1, (i < 3), 1'b0, AB'(i), 4'h0, 32'h0);
            else       drive(0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
            look();
            n_vec++;
            if ({m1_gnt, m0_gnt} !== ((i < 4) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL lock cyc %0d got gnt=%b%b want %b", i, m1_gnt, m0_gnt,
                         (i < 4) ? 2'b01 : 2'b10);
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_lock_limit();
        apply_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 10'h1, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'h2, 4'h0, 32'h0);
        for (int c = 1; c <= ML + 1; c++) begin
            look();
            n_vec++;
            if ({m1_gnt, m0_gnt} !== ((c <= ML) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL lock_limit cyc %0d got gnt=%b%b want %b", c, m1_gnt, m0_gnt,
                         (c <= ML) ? 2'b01 : 2'b10);
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_byte_write();
        logic [DW-1:0] want;
        want = 32'h1122AB44;
        drive(1, 1'b1, 1'b0, 1'b1, 10'h3, 4'hF, 32'h11223344);
        look(); tick();
        drive(1, 1'b1, 1'b0, 1'b1, 10'h3, 4'b0010, 32'h0000AB00);
        look();
        n_vec++;
        if (!(m1_gnt === 1'b1 && sram_write_en === 1'b1 && sram_read_en === 1'b0 && sram_byte_en === 4'b0010 &&
              sram_write_data === 32'h0000AB00 && sram_addr === 10'h3)) begin
            n_bad++;
            $display("FAIL byte_write_bus got gnt=%b wen=%b ren=%b be=%b wd=%h addr=%0h want 1 1 0 0010 0000ab00 3",
                     m1_gnt, sram_write_en, sram_read_en, sram_byte_en, sram_write_data, sram_addr);
        end
        tick();
        drive(1, 1'b1, 1'b0, 1'b0, 10'h3, 4'hF, 32'h0);
        look();
        n_vec++;
        if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL write_no_rvalid got rv=%b%b want 00", m1_rvalid, m0_rvalid);
        end
        tick();
        idle_all();
        look();
        n_vec++;
        if (!(m1_rvalid === 1'b1 && m0_rvalid === 1'b0 && m1_read_data === want)) begin
            n_bad++;
            $display("FAIL byte_readback got rv=%b%b data=%h want rv=10 data=%h",
                     m1_rvalid, m0_rvalid, m1_read_data, want);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int port_seq [8] = '{0, 0, 1, 1, 0, 1, 0, 1};
        for (int i = 0; i <= 8; i++) begin
            idle_all();
            if (i < 8) drive(port_seq[i], 1'b1, 1'b0, 1'b0, AB'(10 + i), 4'hF, 32'h0);
            look();
            n_vec++;
            if ({m1_gnt, m0_gnt} !== exp_gnt || {m1_rvalid, m0_rvalid} !== exp_rvalid) begin
                n_bad++;
                $display("FAIL b2b cyc %0d got gnt=%b%b rv=%b%b want gnt=%b rv=%b",
                         i, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, exp_gnt, exp_rvalid);
            end
            if (i > 0) begin
                n_vec++;
                if ((port_seq[i-1] == 0 ? m0_rvalid : m1_rvalid) !== 1'b1 ||
                    (port_seq[i-1] == 0 ? m0_read_data : m1_read_data) !== exp_rdata) begin
                    n_bad++;
                    $display("FAIL b2b_data cyc %0d port %0d got rv=%b%b data=%h want data=%h",
                             i, port_seq[i-1], m1_rvalid, m0_rvalid, sram_read_data, exp_rdata);
                end
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_reset_mid();
        // Read by m0 leaves the pointer favouring m1; reset must restore m0 priority and kill rvalid.
        drive(0, 1'b1, 1'b0, 1'b0, 10'h5, 4'h0, 32'h0);
        look();
        n_vec++;
        if (m0_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_grant got m0_gnt=%b want 1", m0_gnt);
        end
        tick();
        idle_all();
        rst = 1'b1;
        look();
        n_vec++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_rvalid got rv=%b%b want 00", m1_rvalid, m0_rvalid);
        end
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 10'h1, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'h2, 4'h0, 32'h0);
        look();
        n_vec++;
        if ({m1_gnt, m0_gnt, m0_rvalid} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_mid_tie got gnt=%b%b rv0=%b want gnt=01 rv0=0", m1_gnt, m0_gnt, m0_rvalid);
        end
        tick();
        // Locked tenure by m1 aborted by reset: m0 alone must then be served.
        idle_all();
        look(); tick();
        drive(1, 1'b1, 1'b1, 1'b0, 10'h4, 4'h0, 32'h0);
        look(); tick();
        idle_all();
        rst = 1'b1;
        drive(1, 1'b1, 1'b1, 1'b0, 10'h4, 4'h0, 32'h0);
        look();
        n_vec++;
        if ({m1_gnt, m0_gnt} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_abort_hold got gnt=%b%b want 00", m1_gnt, m0_gnt);
        end
        tick();
        rst = 1'b0;
        idle_all();
        drive(0, 1'b1, 1'b0, 1'b0, 10'h6, 4'h0, 32'h0);
        look();
        n_vec++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_abort_release got gnt=%b%b want 01", m1_gnt, m0_gnt);
        end
        tick();
        idle_all();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < 2; p++)
                drive(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 1'($urandom),
                      AB'($urandom_range(0, NADDR-1)), 4'($urandom), $urandom);
            look();
            n_vec++;
            if ({m1_gnt, m0_gnt} !== exp_gnt || {m1_rvalid, m0_rvalid} !== exp_rvalid) begin
                n_bad++;
                $display("FAIL rand_ctl cyc %0d got gnt=%b%b rv=%b%b want gnt=%b rv=%b",
                         i, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, exp_gnt, exp_rvalid);
            end
            n_vec++;
            if ({sram_read_en, sram_write_en, sram_addr, sram_byte_en, sram_write_data} !==
                {exp_ren, exp_wen, exp_addr, exp_be, exp_wd}) begin
                n_bad++;
                $display("FAIL rand_bus cyc %0d got ren=%b wen=%b a=%0h be=%b wd=%h want ren=%b wen=%b a=%0h be=%b wd=%h",
                         i, sram_read_en, sram_write_en, sram_addr, sram_byte_en, sram_write_data,
                         exp_ren, exp_wen, exp_addr, exp_be, exp_wd);
            end
            if (exp_rvalid != 2'b00) begin
                n_vec++;
                if ((exp_rvalid[0] ? m0_read_data : m1_read_data) !== exp_rdata) begin
                    n_bad++;
                    $display("FAIL rand_rdata cyc %0d got %h want %h", i,
                             exp_rvalid[0] ? m0_read_data : m1_read_data, exp_rdata);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_init_mem();
        test_single_read();
        test_contention();
        test_lock();
        test_lock_limit();
        test_byte_write();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
